cpu_trace_buffer: RTL

- On-chip instruction trace capture for the 16-bit RISC CPU; synthesizable successor to the bench-side PC/IR monitor.
- Samples {timestamp, PC, IR} on every instruction-register load into a circular buffer. Width, depth and post-trigger length are parametrised.
- Two capture modes: fill-and-stop, and PC-match trigger with post-trigger window.
- Captured entries drain oldest-first through a valid/ready read port, for readout by a debug host or testbench.

---
 rtl/cpu_trace_buffer_if.sv | 44 ++++
 rtl/cpu_trace_buffer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer_if.sv
// rtl/cpu_trace_buffer_if.sv - capture, control and readout signal bundle for cpu_trace_buffer
//
// Purpose: groups the trace buffer's capture, control and readout signals.
//   master: the CPU/debug side. It drives cap_en, pc_in, ir_in, mode, trig_pc,
//           arm and rd_ready, and observes the read port and status.
//   slave : cpu_trace_buffer itself.
// Signals:
//   cap_en, pc_in, ir_in   sample strobe and the {PC, IR} being loaded
//   mode, trig_pc, arm     capture configuration and start pulse
//   rd_valid, rd_ready     read handshake (oldest entry first)
//   rd_stamp, rd_pc, rd_ir contents of the entry at the head of the buffer
//   count, state, triggered status

interface cpu_trace_buffer_if #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 5,
   parameter int STAMP_W    = 16
);
   logic                  cap_en;
   logic [ADDR_W-1:0]     pc_in;
   logic [DATA_W-1:0]     ir_in;
   logic                  mode;
   logic [ADDR_W-1:0]     trig_pc;
   logic                  arm;
   logic                  rd_ready;
   logic                  rd_valid;
   logic [STAMP_W-1:0]    rd_stamp;
   logic [ADDR_W-1:0]     rd_pc;
   logic [DATA_W-1:0]     rd_ir;
   logic [DEPTH_LOG2:0]   count;
   logic [1:0]            state;
   logic                  triggered;

   modport master (
      output cap_en, pc_in, ir_in, mode, trig_pc, arm, rd_ready,
      input  rd_valid, rd_stamp, rd_pc, rd_ir, count, state, triggered
   );

   modport slave (
      input  cap_en, pc_in, ir_in, mode, trig_pc, arm, rd_ready,
      output rd_valid, rd_stamp, rd_pc, rd_ir, count, state, triggered
   );
endinterface

// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - on-chip PC/IR instruction trace capture buffer
//
// Purpose: on every IR load (cap_en), records {timestamp, PC, IR} into a
//   circular buffer. There are two capture modes:
//   - FILL: capture stops once the buffer is full.
//   - TRIG: the buffer runs circularly until the PC matches trig_pc, then
//     records POST_TRIG further entries.
//   In DONE, the entries drain oldest-first through a valid/ready port.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    cpu_trace_buffer_if.slave; capture inputs, control, read port, status

module cpu_trace_buffer #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 5,
   parameter int STAMP_W    = 16,
   parameter int POST_TRIG  = 8
) (
   input  logic               clk,
   input  logic               reset,
   cpu_trace_buffer_if.slave  bus
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int ENT_W = STAMP_W + ADDR_W + DATA_W;

   localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_LAST  = (DEPTH_LOG2+1)'(DEPTH - 1);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2-1:0] POST_INIT = DEPTH_LOG2'(POST_TRIG);
   localparam logic [STAMP_W-1:0]    STAMP_ONE = STAMP_W'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_CAPTURE = 2'b01,
      S_POST    = 2'b10,
      S_DONE    = 2'b11
   } state_t;

   state_t                 st;
   logic [STAMP_W-1:0]     stamp;
   logic [DEPTH_LOG2-1:0]  wr_ptr;
   logic [DEPTH_LOG2-1:0]  rd_ptr;
   logic [DEPTH_LOG2-1:0]  post_cnt;
   logic [DEPTH_LOG2:0]    cnt;
   logic                   trig_mode;
   logic [ADDR_W-1:0]      trig_pc_q;
   logic                   trig_q;

   logic [ENT_W-1:0]       mem [DEPTH];
   logic [ENT_W-1:0]       rd_ent;

   logic                   wr_en;
   logic                   pop;
   logic                   full;
   logic                   pc_hit;

   // arm outranks a write in the same cycle, so the arm-cycle sample is dropped.
   assign wr_en  = bus.cap_en && !bus.arm && (st == S_CAPTURE || st == S_POST);
   assign full   = (cnt == CNT_FULL);
   assign pc_hit = (bus.pc_in == trig_pc_q);
   assign pop    = (st == S_DONE) && (cnt != '0) && bus.rd_ready && !bus.arm;

   // Trace storage has no reset; only the pointers and count define its contents.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         mem[wr_ptr] <= {stamp, bus.pc_in, bus.ir_in};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st        <= S_IDLE;
         stamp     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         post_cnt  <= '0;
         cnt       <= '0;
         trig_mode <= 1'b0;
         trig_pc_q <= '0;
         trig_q    <= 1'b0;
      end else begin
         stamp <= stamp + STAMP_ONE;
         if (bus.arm) begin
            st        <= S_CAPTURE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            trig_q    <= 1'b0;
            trig_mode <= bus.mode;
            trig_pc_q <= bus.trig_pc;
            post_cnt  <= POST_INIT;
         end else begin
            if (wr_en) begin
               wr_ptr <= wr_ptr + PTR_ONE;
               // A full buffer overwrites its oldest entry, so the head moves too.
               if (full) begin
                  rd_ptr <= rd_ptr + PTR_ONE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end

               if (st == S_POST) begin
                  post_cnt <= post_cnt - PTR_ONE;
                  if (post_cnt == PTR_ONE) begin
                     st <= S_DONE;
                  end
               end else if (!trig_mode) begin
                  if (cnt == CNT_LAST) begin
                     st <= S_DONE;
                  end
               end else if (pc_hit) begin
                  trig_q <= 1'b1;
                  if (POST_TRIG == 0) begin
                     st <= S_DONE;
                  end else begin
                     st       <= S_POST;
                     post_cnt <= POST_INIT;
                  end
               end
            end

            if (pop) begin
               rd_ptr <= rd_ptr + PTR_ONE;
               cnt    <= cnt - CNT_ONE;
            end
         end
      end
   end

   assign rd_ent        = mem[rd_ptr];
   assign bus.rd_stamp  = rd_ent[ENT_W-1 -: STAMP_W];
   assign bus.rd_pc     = rd_ent[DATA_W +: ADDR_W];
   assign bus.rd_ir     = rd_ent[DATA_W-1:0];
   assign bus.rd_valid  = (st == S_DONE) && (cnt != '0);
   assign bus.count     = cnt;
   assign bus.state     = st;
   assign bus.triggered = trig_q;

endmodule
